// File: rtl/sprdma_ctrl.sv
// Sprite-DMA sequencer: on a CPU write to $4014 it halts the CPU and copies one
// page of memory into PPU OAMDATA with alternating read/write bus cycles.
module sprdma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cpu_ce_in,
    input  logic [15:0] cpu_a_in,
    input  logic [7:0]  cpu_dout_in,
    input  logic        cpu_r_nw_in,
    input  logic [7:0]  mem_din_in,
    output logic        halt_out,
    output logic        active_out,
    output logic [15:0] dma_a_out,
    output logic [7:0]  dma_d_out,
    output logic        dma_r_nw_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t      state_q, state_d;
    logic        parity_q, parity_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  page_q, page_d;
    logic        halt_q, halt_d;
    logic        active_q, active_d;
    logic [15:0] dma_a_q, dma_a_d;
    logic [7:0]  dma_d_q, dma_d_d;
    logic        dma_r_nw_q, dma_r_nw_d;

    // Outputs are registered as a function of the state being entered, so the
    // bus cycle a state describes is presented for the whole tick it occupies.
    always_comb begin
        state_d    = state_q;
        parity_d   = parity_q;
        idx_d      = idx_q;
        page_d     = page_q;
        halt_d     = halt_q;
        active_d   = active_q;
        dma_a_d    = dma_a_q;
        dma_d_d    = dma_d_q;
        dma_r_nw_d = dma_r_nw_q;

        if (cpu_ce_in) begin
            parity_d = ~parity_q;
            case (state_q)
                S_IDLE: begin
                    if (!cpu_r_nw_in && cpu_a_in == DMA_REG_ADDR) begin
                        page_d  = cpu_dout_in;
                        idx_d   = 8'h00;
                        halt_d  = 1'b1;
                        state_d = S_HALT;
                    end
                end
                S_HALT: begin
                    // Wait for the CPU's first halted read; reads must land on parity 0.
                    if (cpu_r_nw_in) begin
                        if (parity_q) begin
                            state_d    = S_READ;
                            active_d   = 1'b1;
                            dma_a_d    = {page_q, idx_q};
                            dma_r_nw_d = 1'b1;
                        end else begin
                            state_d = S_ALIGN;
                        end
                    end
                end
                S_ALIGN: begin
                    state_d    = S_READ;
                    active_d   = 1'b1;
                    dma_a_d    = {page_q, idx_q};
                    dma_r_nw_d = 1'b1;
                end
                S_READ: begin
                    state_d    = S_WRITE;
                    dma_a_d    = OAM_DATA_ADDR;
                    dma_d_d    = mem_din_in;
                    dma_r_nw_d = 1'b0;
                end
                S_WRITE: begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = S_IDLE;
                        halt_d     = 1'b0;
                        active_d   = 1'b0;
                        dma_a_d    = 16'h0000;
                        dma_r_nw_d = 1'b1;
                    end else begin
                        idx_d      = idx_q + 8'd1;
                        state_d    = S_READ;
                        dma_a_d    = {page_q, idx_q + 8'd1};
                        dma_r_nw_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            parity_q   <= 1'b0;
            idx_q      <= 8'h00;
            page_q     <= 8'h00;
            halt_q     <= 1'b0;
            active_q   <= 1'b0;
            dma_a_q    <= 16'h0000;
            dma_d_q    <= 8'h00;
            dma_r_nw_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            parity_q   <= parity_d;
            idx_q      <= idx_d;
            page_q     <= page_d;
            halt_q     <= halt_d;
            active_q   <= active_d;
            dma_a_q    <= dma_a_d;
            dma_d_q    <= dma_d_d;
            dma_r_nw_q <= dma_r_nw_d;
        end
    end

    assign halt_out     = halt_q;
    assign active_out   = active_q;
    assign dma_a_out    = dma_a_q;
    assign dma_d_out    = dma_d_q;
    assign dma_r_nw_out = dma_r_nw_q;

endmodule

// File: tb/tb_sprdma_ctrl.sv
// Bench for sprdma_ctrl: transfer-level model (tick numbering from the halted
// read) checked against the DUT every clock, plus literal checks on lengths.
module tb_sprdma_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        cpu_ce_in;
    logic [15:0] cpu_a_in;
    logic [7:0]  cpu_dout_in;
    logic        cpu_r_nw_in;
    logic [7:0]  mem_din_in;
    logic        halt_out;
    logic        active_out;
    logic [15:0] dma_a_out;
    logic [7:0]  dma_d_out;
    logic        dma_r_nw_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    sprdma_ctrl dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .cpu_ce_in   (cpu_ce_in),
        .cpu_a_in    (cpu_a_in),
        .cpu_dout_in (cpu_dout_in),
        .cpu_r_nw_in (cpu_r_nw_in),
        .mem_din_in  (mem_din_in),
        .halt_out    (halt_out),
        .active_out  (active_out),
        .dma_a_out   (dma_a_out),
        .dma_d_out   (dma_d_out),
        .dma_r_nw_out(dma_r_nw_out)
    );

    // Memory contents seen by DMA reads.
    function automatic logic [7:0] mem_of(input logic [15:0] a);
        return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h3C;
    endfunction

    assign mem_din_in = mem_of(dma_a_out);

    // Model: 0 = idle, 1 = halted waiting for the CPU read, 2 = transfer.
    // During a transfer, t numbers ticks from the halted read (t=1); with an
    // optional alignment tick, u = t - align gives READ on odd u and WRITE on even u.
    int          mdl_st = 0;
    logic        mdl_par = 1'b0;
    logic [7:0]  mdl_page = 8'h00;
    int          mdl_align = 0;
    int          mdl_t = 0;
    int          mdl_last_len = 0;
    int          halt_ticks = 0;

    always @(posedge clk_in) begin
        if (rst_in) begin
            mdl_st  = 0;
            mdl_par = 1'b0;
        end else if (cpu_ce_in) begin
            if (halt_out) halt_ticks++;
            case (mdl_st)
                0: if (!cpu_r_nw_in && cpu_a_in == 16'h4014) begin
                    mdl_page = cpu_dout_in;
                    mdl_st   = 1;
                end
                1: if (cpu_r_nw_in) begin
                    mdl_align = (mdl_par == 1'b0) ? 1 : 0;
                    mdl_t     = 1;
                    mdl_st    = 2;
                end
                default: begin
                    mdl_t++;
                    if (mdl_t - mdl_align == 513) begin
                        mdl_last_len = mdl_t;
                        mdl_st       = 0;
                    end
                end
            endcase
            mdl_par = ~mdl_par;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_cycle();
        logic        eh, ea, ernw;
        logic [15:0] exa;
        logic [7:0]  exd;
        int          u, k;
        eh = (mdl_st != 0);
        ea = 1'b0; ernw = 1'b1; exa = 16'h0000; exd = 8'h00;
        if (mdl_st == 2) begin
            u = mdl_t - mdl_align;
            if (u > 0) begin
                k  = u - 1;
                ea = 1'b1;
                if (k % 2 == 0) begin
                    exa = {mdl_page, 8'(k / 2)};
                end else begin
                    exa  = 16'h2004;
                    exd  = mem_of({mdl_page, 8'(k / 2)});
                    ernw = 1'b0;
                end
            end
        end
        chk("halt", 32'(halt_out), 32'(eh));
        chk("active", 32'(active_out), 32'(ea));
        if (ea) begin
            chk("addr", 32'(dma_a_out), 32'(exa));
            chk("r_nw", 32'(dma_r_nw_out), 32'(ernw));
            if (!ernw) chk("wdata", 32'(dma_d_out), 32'(exd));
        end
    endtask

    task automatic step();
        @(negedge clk_in);
        cmp_cycle();
    endtask

    task automatic set_in(input logic ce, input logic [15:0] a, input logic [7:0] d, input logic rnw);
        cpu_ce_in   = ce;
        cpu_a_in    = a;
        cpu_dout_in = d;
        cpu_r_nw_in = rnw;
    endtask

    // Full transfer: want = parity of the halted-read tick.
    task automatic run_xfer(input logic [7:0] page, input logic want, input int holds,
                            input int gap_max, input logic inject);
        int  h0, cnt, exp_len;
        logic inj;
        h0 = halt_ticks;
        while ((mdl_par ^ 1'((holds + 1) % 2)) != want) begin
            set_in(1'b1, 16'h0000, 8'h00, 1'b1);
            step();
        end
        set_in(1'b1, 16'h4014, page, 1'b0);
        step();
        for (int h = 0; h < holds; h++) begin
            set_in(1'b1, 16'h4015, 8'h77, 1'b0);
            step();
        end
        set_in(1'b1, 16'h8000, 8'h00, 1'b1);
        step();
        cnt = 0;
        while (mdl_st != 0 && cnt < 4000) begin
            repeat ($urandom_range(0, gap_max)) begin
                set_in(1'b0, 16'h4014, 8'h99, 1'b0);
                step();
            end
            inj = inject && ($urandom_range(0, 3) == 0);
            set_in(1'b1, inj ? 16'h4014 : 16'h1234, 8'($urandom), inj ? 1'b0 : 1'b1);
            step();
            cnt++;
        end
        chk("timeout", 32'(cnt < 4000), 32'd1);
        set_in(1'b0, 16'h0000, 8'h00, 1'b1);
        step();
        exp_len = want ? 513 : 514;
        chk("xfer_len", 32'(mdl_last_len), 32'(exp_len));
        chk("align_ticks", 32'(mdl_align), want ? 32'd0 : 32'd1);
        chk("halt_ticks", 32'(halt_ticks - h0), 32'(exp_len + holds));
    endtask

    initial begin
        int cnt;
        // Reset with a simultaneous $4014 write, which must be discarded.
        rst_in = 1'b1;
        set_in(1'b1, 16'h4014, 8'h12, 1'b0);
        step();
        step();
        chk("rst_halt", 32'(halt_out), 32'd0);
        chk("rst_active", 32'(active_out), 32'd0);
        chk("rst_addr", 32'(dma_a_out), 32'h0);
        chk("rst_data", 32'(dma_d_out), 32'h0);
        chk("rst_r_nw", 32'(dma_r_nw_out), 32'd1);
        rst_in = 1'b0;
        set_in(1'b1, 16'h0000, 8'h00, 1'b1);
        repeat (3) step();
        chk("no_trig_after_rst", 32'(halt_out), 32'd0);

        run_xfer(8'h02, 1'b1, 0, 0, 1'b0);  // aligned start
        run_xfer(8'h02, 1'b0, 0, 0, 1'b0);  // one ALIGN tick
        run_xfer(8'h37, 1'b1, 3, 0, 1'b0);  // CPU finishes 3 writes first
        run_xfer(8'hFF, 1'b0, 0, 3, 1'b0);  // top page, ce gaps
        run_xfer(8'h81, 1'b1, 1, 1, 1'b1);  // re-triggers mid-transfer

        // Reset while WRITE of idx 0x40 is on the bus.
        set_in(1'b1, 16'h4014, 8'h03, 1'b0);
        step();
        set_in(1'b1, 16'h8000, 8'h00, 1'b1);
        step();
        cnt = 0;
        while (!(mdl_st == 2 && mdl_t - mdl_align - 1 == 2 * 8'h40 + 1) && cnt < 2000) begin
            set_in(1'b1, 16'h1234, 8'h00, 1'b1);
            step();
            cnt++;
        end
        chk("reach_idx40", 32'(cnt < 2000), 32'd1);
        chk("pre_rst_addr", 32'(dma_a_out), 32'h2004);
        rst_in = 1'b1;
        set_in(1'b1, 16'h4014, 8'h09, 1'b0);
        step();
        chk("mid_rst_halt", 32'(halt_out), 32'd0);
        chk("mid_rst_active", 32'(active_out), 32'd0);
        chk("mid_rst_r_nw", 32'(dma_r_nw_out), 32'd1);
        chk("mid_rst_addr", 32'(dma_a_out), 32'h0);
        rst_in = 1'b0;
        set_in(1'b0, 16'h0000, 8'h00, 1'b1);
        step();
        run_xfer(8'h05, 1'b1, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
